// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope acquisition path: sample and
// decimation widths, trigger edge encoding, sequencer states and the
// trigger-crossing test used by the sequencer.
package osc_pkg;

  localparam int SAMPLE_W = 8;
  localparam int DECI_W   = 10;

  localparam logic EDGE_FALL = 1'b0;
  localparam logic EDGE_RISE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } acq_state_t;

  // True when the step prev -> cur crosses level in the selected direction.
  // A crossing needs a real previous sample, so nothing fires without one.
  function automatic logic trig_cross(
    input logic [SAMPLE_W-1:0] prev,
    input logic [SAMPLE_W-1:0] cur,
    input logic [SAMPLE_W-1:0] level,
    input logic                edge_sel,
    input logic                prev_valid
  );
    logic hit;
    hit = 1'b0;
    if (prev_valid) begin
      if (edge_sel == EDGE_RISE) begin
        hit = (prev < level) && (cur >= level);
      end else if (edge_sel == EDGE_FALL) begin
        hit = (prev > level) && (cur <= level);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/wave_decimator.sv
// Keep-1-of-N sample decimator. The rate is captured on i_clear (frame
// start) so a rate change during a frame only applies to the next frame.
// A rate of 0 or 1 keeps every sample.
module wave_decimator
  import osc_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_valid,
  input  logic [DECI_W-1:0] i_rate,
  output logic              o_dsample
);

  logic [DECI_W-1:0] r_rate;
  logic [DECI_W-1:0] r_cnt;
  logic [DECI_W-1:0] w_last;

  // Highest count value before wrapping; rates 0 and 1 collapse to 0.
  assign w_last    = (r_rate <= DECI_W'(1)) ? '0 : r_rate - DECI_W'(1);
  assign o_dsample = i_valid && (r_cnt == '0);

  // Capture the rate and restart counting on clear; otherwise count strobes.
  // NOTE: sequential state uses non-blocking (<=) so every register updates
  // from pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_rate <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_rate <= i_rate;
      r_cnt  <= '0;
    end else if (i_valid) begin
      r_cnt <= (r_cnt >= w_last) ? '0 : r_cnt + DECI_W'(1);
    end
  end

endmodule

// File: rtl/wave_acq_ctrl.sv
// Acquisition sequencer: decimates the ADC stream into the circular
// waveform RAM, keeps PRE_LEN samples of pre-trigger history, captures the
// post-trigger segment after a level crossing and holds the finished frame
// until the display path acknowledges it.
module wave_acq_ctrl
  import osc_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int PRE_LEN = 150
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] ad_data,
  input  logic                ad_valid,
  input  logic [DECI_W-1:0]   deci_rate,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_edge,
  input  logic                wave_run,
  input  logic                frame_ack,
  output logic                ram_wr_en,
  output logic [ADDR_W-1:0]   ram_wr_addr,
  output logic [SAMPLE_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0]   trig_addr,
  output logic                frame_done
);

  localparam int DEPTH    = 1 << ADDR_W;
  // Samples written after the trigger sample itself.
  localparam int POST_LEN = DEPTH - PRE_LEN - 1;

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_LEN - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_LEN - 1);

  acq_state_t r_state;
  acq_state_t w_state_nxt;

  logic w_start;
  logic w_dsample;
  logic w_write;
  logic w_trig;

  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_pre_cnt;
  logic [ADDR_W-1:0]   r_post_cnt;
  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prev_valid;

  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [SAMPLE_W-1:0] r_wr_data;
  logic [ADDR_W-1:0]   r_trig_addr;
  logic                r_frame_done;

  // A new frame starts on the IDLE -> PRE transition.
  assign w_start = (r_state == ST_IDLE) && wave_run;

  wave_decimator u_decimator (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .i_clear   (w_start),
    .i_valid   (ad_valid),
    .i_rate    (deci_rate),
    .o_dsample (w_dsample)
  );

  // Next-state logic with write and trigger strobes for the current dsample.
  // NOTE: every output of this block is given a default first so that no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_write     = 1'b0;
    w_trig      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (wave_run) w_state_nxt = ST_IDLE == r_state ? ST_PRE : r_state;
      end
      ST_PRE: begin
        // Stopping before the trigger abandons the frame; the dsample of
        // this cycle is dropped.
        if (!wave_run) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dsample) begin
          w_write = 1'b1;
          if (r_pre_cnt == PRE_LAST) w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!wave_run) begin
          w_state_nxt = ST_IDLE;
        end else if (w_dsample) begin
          w_write = 1'b1;
          w_trig  = trig_cross(r_prev, ad_data, trig_level, trig_edge,
                               r_prev_valid);
          if (w_trig) w_state_nxt = ST_POST;
        end
      end
      ST_POST: begin
        // Once triggered the frame always completes, even if stopped.
        if (w_dsample) begin
          w_write = 1'b1;
          if (r_post_cnt == POST_LAST) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (frame_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write pointer, frame counters, previous-sample history and RAM port.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_trig_addr  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en <= w_write;
      // Rises one cycle after DONE is entered, drops right after the ack.
      r_frame_done <= (r_state == ST_DONE) && !frame_ack;

      if (w_start) begin
        r_wr_ptr     <= '0;
        r_pre_cnt    <= '0;
        r_post_cnt   <= '0;
        r_prev_valid <= 1'b0;
      end

      if (w_write) begin
        r_wr_addr    <= r_wr_ptr;
        r_wr_data    <= ad_data;
        // DEPTH is a power of two, so the natural wrap is the circular wrap.
        r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
        r_prev       <= ad_data;
        r_prev_valid <= 1'b1;
        if (r_state == ST_PRE)  r_pre_cnt  <= r_pre_cnt + ADDR_W'(1);
        if (r_state == ST_POST) r_post_cnt <= r_post_cnt + ADDR_W'(1);
      end

      if (w_trig) r_trig_addr <= r_wr_ptr;
    end
  end

  assign ram_wr_en   = r_wr_en;
  assign ram_wr_addr = r_wr_addr;
  assign ram_wr_data = r_wr_data;
  assign trig_addr   = r_trig_addr;
  assign frame_done  = r_frame_done;

endmodule
